// File: rtl/calc_pkg.sv
// Shared operation codes and FSM state encodings
// for the switch calculator sequencer.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton conditioner: 2-flop sync, stability counter, rising-edge pulse.
// Ports: clk_i, reset_i (sync, active-high), pb_raw_i (async) -> pulse_o (1 cycle).
module pb_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pb_raw_i,
  output logic pulse_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;

  // The accepted level only follows the synchronised input after it has
  // disagreed with it for DB_CYCLES consecutive cycles.
  always_comb begin
    sync_d   = {sync_q[0], pb_raw_i};
    stable_d = stable_q;
    cnt_d    = '0;
    prev_d   = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
    end
  end

  assign pulse_o = stable_q & ~prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operation stage: collects A, then B+op via the enter button, computes.
// Ports: clk, reset, sw, op_sel, enter -> result, ans_en, busy, ovf, err, state_dbg.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       op_sel,
  input  logic             enter,
  output logic [WIDTH-1:0] result,
  output logic             ans_en,
  output logic             busy,
  output logic             ovf,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int IW = $clog2(WIDTH) + 1;

  logic enter_pulse;

  pb_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk_i   (clk),
    .reset_i (reset),
    .pb_raw_i(enter),
    .pulse_o (enter_pulse)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    it_q, it_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             ans_q, ans_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   mul_s;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_sh;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_try;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_sh;
  logic             b_zero;
  logic             iter;
  logic             last;

  assign add_s = {1'b0, a_q} + {1'b0, b_q};
  assign sub_s = {1'b0, a_q} - {1'b0, b_q};

  // Shift-add: {carry, acc, sh} shifts right; sh starts as A, ends as low half.
  assign mul_s   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
  assign mul_acc = mul_s[WIDTH:1];
  assign mul_sh  = {mul_s[0], sh_q[WIDTH-1:1]};

  // Restoring divide: {acc, sh} shifts left; quotient bits enter sh from the right.
  assign div_rem = {acc_q, sh_q[WIDTH-1]};
  assign div_try = div_rem - {1'b0, b_q};
  assign div_ge  = ~div_try[WIDTH];
  assign div_acc = div_ge ? div_try[WIDTH-1:0] : div_rem[WIDTH-1:0];
  assign div_sh  = {sh_q[WIDTH-2:0], div_ge};

  assign b_zero = (b_q == '0);
  assign iter   = (op_q == OP_MUL) || ((op_q == OP_DIV) && !b_zero);
  assign last   = iter ? (it_q == IW'(WIDTH - 1)) : 1'b1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    it_d    = it_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    ans_d   = 1'b0;
    unique case (state_q)
      S_A: begin
        if (enter_pulse) begin
          a_d     = sw;
          state_d = S_B;
        end
      end
      S_B: begin
        if (enter_pulse) begin
          b_d     = sw;
          op_d    = op_sel;
          acc_d   = '0;
          sh_d    = a_q;
          it_d    = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        it_d = it_q + IW'(1);
        unique case (op_q)
          OP_ADD: begin
            res_d = add_s[WIDTH-1:0];
            ovf_d = add_s[WIDTH];
            err_d = 1'b0;
          end
          OP_SUB: begin
            res_d = sub_s[WIDTH-1:0];
            ovf_d = sub_s[WIDTH];
            err_d = 1'b0;
          end
          OP_MUL: begin
            acc_d = mul_acc;
            sh_d  = mul_sh;
            if (last) begin
              res_d = mul_sh;
              ovf_d = |mul_acc;
              err_d = 1'b0;
            end
          end
          OP_DIV: begin
            if (b_zero) begin
              res_d = '1;
              ovf_d = 1'b0;
              err_d = 1'b1;
            end else begin
              acc_d = div_acc;
              sh_d  = div_sh;
              if (last) begin
                res_d = div_sh;
                ovf_d = 1'b0;
                err_d = 1'b0;
              end
            end
          end
        endcase
        if (last) begin
          ans_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (enter_pulse) begin
          state_d = S_A;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      acc_q   <= '0;
      sh_q    <= '0;
      it_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ans_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      it_q    <= it_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ans_q   <= ans_d;
    end
  end

  assign result    = res_q;
  assign ans_en    = ans_q;
  assign busy      = (state_q == S_EXEC);
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
